dmem_responder: RTL



---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_lane.sv | 36 +++
 rtl/dmem_responder.sv | 118 +++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and lane-mask helpers for the data-memory responder
package dmem_pkg;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} mem_size_e;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_e;

    localparam logic [7:0] LANE_B = 8'h01;
    localparam logic [7:0] LANE_H = 8'h03;
    localparam logic [7:0] LANE_W = 8'h0F;
    localparam logic [7:0] LANE_D = 8'hFF;

    // Byte-enable pattern for an access of the given size, before shifting to its offset
    function automatic logic [7:0] lane_mask(mem_size_e size);
        return size == SZ_B ? LANE_B : size == SZ_H ? LANE_H : size == SZ_W ? LANE_W : LANE_D;
    endfunction

    // Offset bits that must be zero for a naturally aligned access
    function automatic logic [2:0] align_mask(mem_size_e size);
        return size == SZ_B ? 3'd0 : size == SZ_H ? 3'd1 : size == SZ_W ? 3'd3 : 3'd7;
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// dmem_lane: little-endian store byte-merge, load extract/extend and misalignment flag
module dmem_lane
    import dmem_pkg::*;
(
    input  mem_size_e   size_i,
    input  logic [2:0]  off_i,
    input  logic        uns_i,
    input  logic [63:0] wdata_i,
    input  logic [63:0] word_i,
    output logic [63:0] merged_o,
    output logic [63:0] rdata_o,
    output logic        misalign_o
);

    logic [7:0]  bmask;
    logic [63:0] bitmask;
    logic [63:0] wsh;
    logic [63:0] rsh;
    logic        sx;

    // Merge shifted store lanes into the old word and extract/extend the load lanes
    always_comb begin
        bmask = lane_mask(size_i) << off_i;
        bitmask = '0;
        for (int b = 0; b < 8; b++) bitmask[8*b +: 8] = {8{bmask[b]}};
        wsh = wdata_i << {off_i, 3'b000};
        merged_o = (word_i & ~bitmask) | (wsh & bitmask);
        rsh = word_i >> {off_i, 3'b000};
        sx = ~uns_i;
        rdata_o = size_i == SZ_B ? {{56{sx & rsh[7]}}, rsh[7:0]} :
                  size_i == SZ_H ? {{48{sx & rsh[15]}}, rsh[15:0]} :
                  size_i == SZ_W ? {{32{sx & rsh[31]}}, rsh[31:0]} : rsh;
        misalign_o = |(off_i & align_mask(size_i));
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency valid/ready load/store responder; DMEM_B2B_EN enables back-to-back accept
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 128,
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [63:0] req_addr_i,
    input  logic [63:0] req_wdata_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [63:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;

    dmem_state_e   state;
    logic [CW-1:0] cnt;
    logic          we_q, uns_q;
    logic [63:0]   addr_q, wdata_q;
    mem_size_e     size_q;

    logic          accept, enter, use_q, a_we, a_uns, err_c, misalign, wr_en;
    logic [63:0]   a_addr, a_wdata, word, merged, lane_rdata;
    mem_size_e     a_size;
    logic [IW-1:0] idx;
    logic [63:0]   mem [DEPTH];

`ifdef DMEM_B2B_EN
    assign req_ready_o = state == IDLE || (state == RESP && rsp_ready_i);
`else
    assign req_ready_o = state == IDLE;
`endif

    // Access operands come from the capture registers in WAIT, straight from the request otherwise
    always_comb begin
        accept = req_valid_i && req_ready_o;
        use_q = state == WAIT;
        a_we = use_q ? we_q : req_we_i;
        a_uns = use_q ? uns_q : req_unsigned_i;
        a_addr = use_q ? addr_q : req_addr_i;
        a_wdata = use_q ? wdata_q : req_wdata_i;
        a_size = use_q ? size_q : mem_size_e'(req_size_i);
        idx = a_addr[IW+2:3];
        word = mem[idx];
        err_c = misalign || |a_addr[63:IW+3];
        enter = !rst_i && ((state == WAIT && cnt == CW'(1)) || (accept && LATENCY == 1));
        wr_en = enter && a_we && !err_c;
    end

    dmem_lane u_lane (
        .size_i     (a_size),
        .off_i      (a_addr[2:0]),
        .uns_i      (a_uns),
        .wdata_i    (a_wdata),
        .word_i     (word),
        .merged_o   (merged),
        .rdata_o    (lane_rdata),
        .misalign_o (misalign)
    );

    // Stores commit on the edge that enters RESP; array contents survive reset
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[idx] <= merged;
    end

    // Request/response FSM with registered response outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt <= '0;
            we_q <= 1'b0;
            uns_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            size_q <= SZ_B;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o <= 1'b0;
        end else begin
            case (state)
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= RESP;
                end
                RESP: if (rsp_ready_i) begin
                    rsp_valid_o <= 1'b0;
                    state <= IDLE;
                end
                default: ;
            endcase
            if (accept) begin
                we_q <= req_we_i;
                uns_q <= req_unsigned_i;
                addr_q <= req_addr_i;
                wdata_q <= req_wdata_i;
                size_q <= mem_size_e'(req_size_i);
                state <= LATENCY == 1 ? RESP : WAIT;
                cnt <= CW'(LATENCY - 1);
            end
            if (enter) begin
                rsp_valid_o <= 1'b1;
                rsp_rdata_o <= (err_c || a_we) ? 64'd0 : lane_rdata;
                rsp_err_o <= err_c;
            end
        end
    end

endmodule
